// File: rtl/cpu_param.sv
// cpu_param: parametrised multicycle CPU with two-word instructions, 8-entry register file,
// ALU with carry/zero flags and conditional jumps. Define CPU_IMM_EN to enable LDI (000_11_rrr).
module cpu_param #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic          halt,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_rden,
    output logic          mem_wren,
    output logic          waits,
    output logic          fetcha,
    output logic          fetchb,
    output logic          execa,
    output logic          execb,
    output logic [AW-1:0] pc,
    output logic          cflag,
    output logic          zflag,
    input  logic [2:0]    dbg_sel,
    output logic [DW-1:0] dbg_data
);

    typedef enum logic [2:0] {StWait, StFetchA, StFetchB, StExecA, StExecB} stage_e;

    stage_e        stage_q, stage_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] opcode_q, opcode_d, operand_q, operand_d;
    logic [DW-1:0] mdr_q, mdr_d, res_q, res_d;
    logic          cf_tmp_q, cf_tmp_d, zf_tmp_q, zf_tmp_d;
    logic          cflag_q, cflag_d, zflag_q, zflag_d;
    logic [DW-1:0] regs_q [8];
    logic [DW-1:0] regs_d [8];

    logic [7:0]    op;
    logic [2:0]    cls, rsel, ra, rb;
    logic [1:0]    sub;
    logic [AW-1:0] addr;
    logic          is_hlt, is_ld, is_st, is_alu, is_ldi, jump_taken;
    logic [DW:0]   alu_full;

    assign op     = opcode_q[7:0];
    assign cls    = op[7:5];
    assign sub    = op[4:3];
    assign rsel   = op[2:0];
    assign ra     = operand_q[7:5];
    assign rb     = operand_q[4:2];
    assign addr   = operand_q[AW-1:0];
    assign is_hlt = (op == 8'h00);
    assign is_ld  = (cls == 3'b000) && (sub == 2'b01);
    assign is_st  = (cls == 3'b000) && (sub == 2'b10);
    assign is_alu = (cls == 3'b100);
`ifdef CPU_IMM_EN
    assign is_ldi = (cls == 3'b000) && (sub == 2'b11);
`else
    assign is_ldi = 1'b0;
`endif

    always_comb begin
        jump_taken = 1'b0;
        if (cls == 3'b001) begin
            case (op[4:0])
                5'b00000: jump_taken = cflag_q;
                5'b00001: jump_taken = !cflag_q;
                5'b00010: jump_taken = zflag_q;
                5'b00011: jump_taken = !zflag_q;
                5'b11111: jump_taken = 1'b1;
                default:  jump_taken = 1'b0;
            endcase
        end
    end

    // One extra bit holds carry (add) or borrow (subtract).
    always_comb begin
        alu_full = '0;
        unique case (sub)
            2'b00:   alu_full = {1'b0, regs_q[ra]} + {{DW{1'b0}}, 1'b1};
            2'b01:   alu_full = {1'b0, regs_q[ra]} - {{DW{1'b0}}, 1'b1};
            2'b10:   alu_full = {1'b0, regs_q[ra]} + {1'b0, regs_q[rb]};
            default: alu_full = {1'b0, regs_q[ra]} - {1'b0, regs_q[rb]};
        endcase
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_rden  = 1'b0;
        mem_wren  = 1'b0;
        unique case (stage_q)
            StFetchA, StFetchB: begin
                mem_addr = pc_q;
                mem_rden = 1'b1;
            end
            StExecA: begin
                if (is_ld) begin
                    mem_addr = addr;
                    mem_rden = 1'b1;
                end else if (is_st) begin
                    mem_addr  = addr;
                    mem_wdata = regs_q[rsel];
                    mem_wren  = !halt;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        stage_d   = stage_q;
        pc_d      = pc_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;
        mdr_d     = mdr_q;
        res_d     = res_q;
        cf_tmp_d  = cf_tmp_q;
        zf_tmp_d  = zf_tmp_q;
        cflag_d   = cflag_q;
        zflag_d   = zflag_q;
        regs_d    = regs_q;
        // An abort edge changes only the stage.
        if (halt) begin
            stage_d = StWait;
        end else begin
            unique case (stage_q)
                StWait: if (run) stage_d = StFetchA;
                StFetchA: begin
                    opcode_d = mem_rdata;
                    pc_d     = pc_q + 1'b1;
                    stage_d  = StFetchB;
                end
                StFetchB: begin
                    operand_d = mem_rdata;
                    pc_d      = pc_q + 1'b1;
                    stage_d   = StExecA;
                end
                StExecA: begin
                    stage_d = StExecB;
                    if (is_ld) mdr_d = mem_rdata;
                    if (is_alu) begin
                        res_d    = alu_full[DW-1:0];
                        cf_tmp_d = alu_full[DW];
                        zf_tmp_d = (alu_full[DW-1:0] == '0);
                    end
                end
                StExecB: begin
                    stage_d = is_hlt ? StWait : StFetchA;
                    if (is_ld)  regs_d[rsel] = mdr_q;
                    if (is_ldi) regs_d[rsel] = operand_q;
                    if (is_alu) begin
                        regs_d[rsel] = res_q;
                        cflag_d      = cf_tmp_q;
                        zflag_d      = zf_tmp_q;
                    end
                    if (jump_taken) pc_d = addr;
                end
                default: stage_d = StWait;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q   <= StWait;
            pc_q      <= '0;
            opcode_q  <= '0;
            operand_q <= '0;
            mdr_q     <= '0;
            res_q     <= '0;
            cf_tmp_q  <= 1'b0;
            zf_tmp_q  <= 1'b0;
            cflag_q   <= 1'b0;
            zflag_q   <= 1'b0;
            for (int i = 0; i < 8; i++) regs_q[i] <= '0;
        end else begin
            stage_q   <= stage_d;
            pc_q      <= pc_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
            mdr_q     <= mdr_d;
            res_q     <= res_d;
            cf_tmp_q  <= cf_tmp_d;
            zf_tmp_q  <= zf_tmp_d;
            cflag_q   <= cflag_d;
            zflag_q   <= zflag_d;
            regs_q    <= regs_d;
        end
    end

    assign waits    = (stage_q == StWait);
    assign fetcha   = (stage_q == StFetchA);
    assign fetchb   = (stage_q == StFetchB);
    assign execa    = (stage_q == StExecA);
    assign execb    = (stage_q == StExecB);
    assign pc       = pc_q;
    assign cflag    = cflag_q;
    assign zflag    = zflag_q;
    assign dbg_data = regs_q[dbg_sel];

endmodule
